// File: rtl/layer_compositor.sv
// layer_compositor: two-stage priority compositor of keyed display layers, with a
// double-buffered enable mask that only swaps at frame start.
module layer_compositor #(
    parameter int          NUM_LAYERS = 4,
    parameter logic [5:0]  COMP_ID    = 6'b111110,
    parameter logic [23:0] KEY_COLOR  = 24'h9290ff,
    parameter logic [23:0] BG_COLOR   = 24'h9290ff
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write,
    input  logic [31:0]             writedata,
    input  logic [9:0]              hcount,
    input  logic [9:0]              vcount,
    input  logic                    blank_n,
    input  logic [24*NUM_LAYERS-1:0] layer_rgb,
    output logic [23:0]             RGB_output,
    output logic                    pixel_valid,
    output logic [15:0]             frame_count
);
    logic [NUM_LAYERS-1:0] r_pending_mask, r_active_mask, w_mask;
    logic                  r_swap_req, r_hit, r_blank;
    logic [23:0]           r_color, w_color;
    logic                  w_hit, w_frame_start, w_mask_wr, w_commit, w_swap, w_unused;

    assign w_frame_start = hcount == 10'd0 && vcount == 10'd0;
    assign w_mask_wr = write && writedata[31:26] == COMP_ID && writedata[20:17] == 4'h1 &&
                       writedata[16:14] == 3'b101;
    assign w_commit = write && writedata[20:17] == 4'hF;
    assign w_swap = w_frame_start && (r_swap_req || w_commit);
    // The first pixel of a new frame already sees the freshly committed mask.
    assign w_mask = w_swap ? r_pending_mask : r_active_mask;
    assign w_unused = ^{writedata[25:21], writedata[13], writedata[12:NUM_LAYERS]};

    always_comb begin
        w_hit = 1'b0;
        w_color = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (w_mask[i] && layer_rgb[24*i +: 24] != KEY_COLOR) begin
                w_hit = 1'b1;
                w_color = layer_rgb[24*i +: 24];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending_mask <= '1;
            r_active_mask  <= '1;
            r_swap_req     <= 1'b0;
            frame_count    <= '0;
        end else begin
            if (w_mask_wr)
                r_pending_mask <= writedata[NUM_LAYERS-1:0];
            if (w_swap) begin
                r_active_mask <= r_pending_mask;
                r_swap_req    <= 1'b0;
            end else if (w_commit) begin
                r_swap_req <= 1'b1;
            end
            if (w_frame_start)
                frame_count <= frame_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit       <= 1'b0;
            r_color     <= '0;
            r_blank     <= 1'b0;
            RGB_output  <= '0;
            pixel_valid <= 1'b0;
        end else begin
            r_hit       <= w_hit;
            r_color     <= w_color;
            r_blank     <= blank_n;
            RGB_output  <= !r_blank ? 24'h0 : r_hit ? r_color : BG_COLOR;
            pixel_valid <= r_blank;
        end
    end
endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: directed vectors with a due-cycle scoreboard checked by a monitor.
module tb_layer_compositor;
    localparam logic [23:0] K  = 24'h9290ff;
    localparam logic [23:0] BG = 24'h000080;
    localparam logic [9:0]  M  = 10'd5;
    localparam logic [31:0] COMMIT = {6'd0, 5'd0, 4'hF, 3'd0, 1'b0, 13'd0};

    typedef struct {
        int          due;
        logic        v;
        logic [23:0] rgb;
        string       nm;
    } exp_t;

    logic        clk = 0, reset = 0, write = 0, blank_n = 1;
    logic [31:0] writedata = 0;
    logic [9:0]  hcount = M, vcount = M;
    logic [95:0] layer_rgb;
    logic [23:0] RGB_output;
    logic        pixel_valid;
    logic [15:0] frame_count;
    int          cyc = 0, checks = 0, failures = 0;
    exp_t        q[$];

    layer_compositor #(.NUM_LAYERS(4), .COMP_ID(6'b111110), .KEY_COLOR(K), .BG_COLOR(BG)) dut (
        .clk(clk), .reset(reset), .write(write), .writedata(writedata), .hcount(hcount),
        .vcount(vcount), .blank_n(blank_n), .layer_rgb(layer_rgb), .RGB_output(RGB_output),
        .pixel_valid(pixel_valid), .frame_count(frame_count));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.due != cyc || RGB_output !== e.rgb || pixel_valid !== e.v) begin
                failures++;
                $display("FAIL %s: got rgb=%h valid=%b (cycle %0d), want rgb=%h valid=%b (cycle %0d)",
                         e.nm, RGB_output, pixel_valid, cyc, e.rgb, e.v, e.due);
            end
        end
    end

    function automatic logic [95:0] lay(input logic [23:0] a3, a2, a1, a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [31:0] wd_mask(input logic [3:0] m);
        return {6'b111110, 5'd0, 4'h1, 3'b101, 1'b0, 9'd0, m};
    endfunction

    task automatic chk_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [9:0] h, input logic [9:0] v, input logic b, input logic [95:0] rgb,
                        input logic [31:0] wd, input logic wr, input bit chk, input logic [23:0] e,
                        input string nm);
        @(posedge clk);
        #1;
        hcount = h; vcount = v; blank_n = b; layer_rgb = rgb; writedata = wd; write = wr;
        if (chk) q.push_back('{cyc + 2, b, e, nm});
    endtask

    task automatic px(input logic [9:0] h, input logic [9:0] v, input logic b, input logic [95:0] rgb,
                      input logic [23:0] e, input string nm);
        step(h, v, b, rgb, 32'd0, 1'b0, 1'b1, e, nm);
    endtask

    task automatic wr(input logic [95:0] rgb, input logic [31:0] wd, input logic [23:0] e, input string nm);
        step(M, M, 1'b1, rgb, wd, 1'b1, 1'b1, e, nm);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(M, M, 1'b1, layer_rgb, 32'd0, 1'b0, 1'b0, 24'd0, "idle");
    endtask

    initial begin
        logic [95:0] r, r2, r3;
        r  = lay(K, K, 24'h00FF00, 24'hFF0000);
        r2 = lay(K, 24'h333333, 24'h00FF00, 24'hFF0000);
        r3 = lay(K, 24'h333333, 24'h00FF00, K);
        layer_rgb = lay(K, K, K, K);
        repeat (2) @(posedge clk);
        #1;
        chk_val("rst_rgb", {8'd0, RGB_output}, 32'd0);
        chk_val("rst_valid", {31'd0, pixel_valid}, 32'd0);
        chk_val("rst_fc", {16'd0, frame_count}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1;
        layer_rgb = lay(24'h111111, 24'h222222, K, K);
        q.push_back('{cyc + 2, 1'b1, 24'h222222, "prio_l2"});
        px(M, M, 1, lay(K, K, K, 24'hAAAAAA), 24'hAAAAAA, "l0_top");
        px(M, M, 1, lay(24'h11, 24'h22, 24'h123456, K), 24'h123456, "l1_over_key");
        px(M, M, 1, lay(K, K, K, K), BG, "all_key");
        px(M, M, 0, lay(K, K, K, 24'hAAAAAA), 24'h0, "blank_opaque");
        px(M, M, 0, lay(K, K, K, K), 24'h0, "blank_key");
        px(M, M, 1, r, 24'hFF0000, "pre_mask");
        chk_val("fc_none", {16'd0, frame_count}, 32'd0);
        // Mask 1110 written and committed mid-frame; takes effect at frame start only.
        wr(r, wd_mask(4'b1110), 24'hFF0000, "mask_wr");
        px(M, M, 1, r, 24'hFF0000, "after_mask");
        wr(r, COMMIT, 24'hFF0000, "commit");
        px(M, M, 1, r, 24'hFF0000, "hold1");
        px(M, M, 1, r, 24'hFF0000, "hold2");
        px(0, 0, 1, r, 24'h00FF00, "fs_swap");
        px(M, M, 1, r, 24'h00FF00, "new_mask");
        chk_val("fc_1", {16'd0, frame_count}, 32'd1);
        // Mask write racing a frame start uses the old pending value.
        wr(r, wd_mask(4'b1111), 24'h00FF00, "m1111");
        wr(r, COMMIT, 24'h00FF00, "c1111");
        wr(r, COMMIT, 24'h00FF00, "c1111_again");
        px(M, M, 1, r, 24'h00FF00, "pend");
        step(0, 0, 1, r, wd_mask(4'b0000), 1, 1, 24'hFF0000, "fs_wr_race");
        px(M, M, 1, r, 24'hFF0000, "race_after");
        px(M, M, 1, r, 24'hFF0000, "race_after2");
        wr(r, COMMIT, 24'hFF0000, "c0000");
        px(M, M, 1, r, 24'hFF0000, "c0_hold");
        px(0, 0, 1, r, BG, "fs_bg");
        px(M, M, 1, r, BG, "bg_mid");
        px(M, M, 1, lay(1, 2, 3, 4), BG, "bg_any");
        chk_val("fc_3", {16'd0, frame_count}, 32'd3);
        // Commit in the frame-start cycle applies immediately and leaves no request.
        wr(r2, wd_mask(4'b0100), BG, "m0100");
        step(0, 0, 1, r2, COMMIT, 1, 1, 24'h333333, "fs_commit");
        px(M, M, 1, r2, 24'h333333, "l2_mid");
        wr(r2, wd_mask(4'b0001), 24'h333333, "m0001");
        px(0, 0, 1, r2, 24'h333333, "fs_noswap");
        px(M, M, 1, r2, 24'h333333, "still_l2");
        chk_val("fc_5", {16'd0, frame_count}, 32'd5);
        wr(r2, COMMIT, 24'h333333, "c0001");
        idle(3);
        chk_val("fc_5_pre_rst", {16'd0, frame_count}, 32'd5);
        @(posedge clk);
        #1;
        reset = 0;
        #1;
        chk_val("mid_rst_rgb", {8'd0, RGB_output}, 32'd0);
        chk_val("mid_rst_valid", {31'd0, pixel_valid}, 32'd0);
        chk_val("mid_rst_fc", {16'd0, frame_count}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1;
        hcount = M; vcount = M; blank_n = 1; layer_rgb = r3; write = 0;
        q.push_back('{cyc + 2, 1'b1, 24'h00FF00, "post_rst"});
        px(0, 0, 1, r3, 24'h00FF00, "fs_after_rst");
        px(M, M, 1, r3, 24'h00FF00, "mid_after_rst");
        chk_val("fc_after_rst", {16'd0, frame_count}, 32'd1);
        // Writes that must be ignored, followed by a commit of the untouched all-ones mask.
        wr(r, {6'd0, 5'd0, 4'h1, 3'b101, 1'b0, 13'd0}, 24'hFF0000, "bad_sub");
        wr(r, {6'b111110, 5'd0, 4'h1, 3'b000, 1'b0, 13'd0}, 24'hFF0000, "bad_type");
        wr(r, {6'b111110, 5'd0, 4'h2, 3'b101, 1'b0, 13'd0}, 24'hFF0000, "bad_info");
        step(M, M, 1, r, wd_mask(4'b0000), 0, 1, 24'hFF0000, "no_strobe");
        wr(r, COMMIT, 24'hFF0000, "c_ign");
        for (int i = 0; i < 65534; i++) step(0, 0, 1, r, 32'd0, 0, 0, 24'd0, "loop");
        px(M, M, 1, r, 24'hFF0000, "wrap_pre");
        chk_val("fc_ffff", {16'd0, frame_count}, 32'h0000FFFF);
        px(0, 0, 1, r, 24'hFF0000, "fs_wrap");
        px(M, M, 1, r, 24'hFF0000, "post_wrap");
        chk_val("fc_wrap", {16'd0, frame_count}, 32'd0);
        idle(3);
        chk_val("queue_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, giving the number of display-layer inputs (range 2..8).
REQ-002 SHALL have parameter COMP_ID, default 6'b111110, giving the sub_comp code addressing this block.
REQ-003 SHALL have parameter KEY_COLOR, default 24'h9290ff, the transparent/sky colour emitted by display layers.
REQ-004 SHALL have parameter BG_COLOR, default 24'h9290ff, the colour shown when no layer is opaque.
REQ-005 SHALL have port clk, input, 1, the single pixel clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-007 SHALL have port write, input, 1, one-cycle strobe qualifying writedata.
REQ-008 SHALL have port writedata, input, 32, the command word: [31:26] sub_comp, [20:17] info, [16:14] input_type, [12:0] input_msg.
REQ-009 SHALL have port hcount, input, 10, the current pixel column.
REQ-010 SHALL have port vcount, input, 10, the current pixel row.
REQ-011 SHALL have port blank_n, input, 1, 1 = active video.
REQ-012 SHALL have port layer_rgb, input, 24*NUM_LAYERS, where slice i is layer i colour and layer 0 has highest priority.
REQ-013 SHALL have port RGB_output, output, 24, the composited pixel.
REQ-014 SHALL have port pixel_valid, output, 1, the blank_n delayed to align with RGB_output.
REQ-015 SHALL have port frame_count, output, 16, the number of frame starts since reset.

Function
REQ-016 SHALL have a fixed latency of 2 clk from hcount/vcount/layer_rgb/blank_n to RGB_output/pixel_valid.
REQ-017 SHALL register in stage 1 the lowest index i with active_mask[i]=1 and layer_rgb[i]!=KEY_COLOR (hit=1), plus its colour; if none qualifies, hit=0.
REQ-018 SHALL output, in stage 2, RGB_output = 0 when delayed blank_n=0, else the selected colour if hit, else BG_COLOR.
REQ-019 SHALL accept a mask write when write=1, sub_comp==COMP_ID, info==4'h1 and input_type==3'b101: pending_mask <= input_msg[NUM_LAYERS-1:0].
REQ-020 SHALL accept a commit request when write=1 and info==4'hF, regardless of sub_comp: swap_req <= 1.
REQ-021 SHALL ignore all other writedata combinations, and any writedata when write=0.
REQ-022 SHALL treat a frame start as the cycle in which hcount==0 and vcount==0.
REQ-023 SHALL at a frame start increment frame_count, wrapping from 16'hFFFF to 0.
REQ-024 SHALL at a frame start with swap_req=1 set active_mask <= pending_mask and clear swap_req.
REQ-025 SHALL keep active_mask unchanged mid-frame, so no tearing occurs.
REQ-026 Simultaneous mask write and frame start: the commit SHALL use the pre-write pending_mask, and the new value waits for the next commit.
REQ-027 Simultaneous commit write and frame start: the swap SHALL apply at this frame start, and swap_req ends at 0.
REQ-028 SHALL keep repeated commits before a frame start idempotent, so exactly one swap occurs.
REQ-029 SHALL make active_mask=0 produce BG_COLOR on every active pixel.
REQ-030 SHALL treat a layer whose colour equals KEY_COLOR as transparent even when enabled.

Reset
REQ-031 On reset=0, all state SHALL clear asynchronously: RGB_output=0, pixel_valid=0, frame_count=0, swap_req=0, pipeline registers 0, active_mask and pending_mask all ones.
REQ-032 After reset deasserts, outputs SHALL become valid on the 2nd rising clk edge.
REQ-033 Reset asserted mid-frame SHALL discard any pending swap, and active_mask returns to all ones.

Verification
REQ-034 Scenario: with NUM_LAYERS=4 and default mask, drive layer_rgb = {L3=24'h111111, L2=24'h222222, L1=KEY_COLOR, L0=KEY_COLOR} with blank_n=1 -> RGB_output=24'h222222 exactly 2 clk later, with pixel_valid=1.
REQ-035 Scenario: all layers at KEY_COLOR with BG_COLOR=24'h000080 -> RGB_output=24'h000080; then blank_n=0 -> RGB_output=0 and pixel_valid=0 after 2 clk.
REQ-036 Scenario: write a mask of 4'b1110 mid-frame, then a commit, with L0=24'hFF0000 and L1=24'h00FF00 -> output stays 24'hFF0000 until the next hcount=vcount=0, then becomes 24'h00FF00.
REQ-037 Scenario: a mask write of 4'b0000 lands in the same cycle as a frame start that has swap_req=1 from an earlier commit of 4'b1111 -> active_mask=4'b1111, and 4'b0000 applies only after a later commit.
REQ-038 Scenario: reset is pulsed low for 1 cycle while swap_req=1 and frame_count=16'h0005 -> frame_count=0, swap_req=0, outputs 0, and the mask returns to all ones.
REQ-039 Scenario: run 65536 frame starts -> frame_count wraps to 0, and a write with sub_comp!=COMP_ID and info=4'h1 leaves pending_mask unchanged.
